data_mem_responder: RTL and testbench

Word-addressed data-memory responder for the load/store bus driven by the memory stage.
- Bus signals: cyc/stb/we/rd, per-byte enables, separate load/store addresses, stall, ack.
- Adds programmable wait states and abort-on-cyc-drop.
- Sits between the memory stage's bus outputs and the data RAM array, and returns read data, ack and stall to the memory stage.

---
 rtl/data_mem_responder_pkg.sv | 23 ++
 rtl/data_mem_responder_byte_merge.sv | 33 +++
 rtl/data_mem_responder.sv | 219 +++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg
//   Shared definitions for the data-memory responder and its lane-merge helper:
//   FSM state encoding, wait-counter width and the byte-lane count helper.
package data_mem_responder_pkg;

  // Responder FSM: idle/accepting, counting wait states, one-cycle response
  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_RESP = 2'd2
  } dmState_t;

  // Wait counter is wide enough for the largest supported latency (15)
  localparam int DM_CNT_W = 4;

  localparam int DM_DEFAULT_DWIDTH = 32;

  // Number of byte lanes in a data word (DWIDTH/8)
  function automatic int dmLanes(input int dwidth);
    return dwidth / 8;
  endfunction

endpackage

// File: rtl/data_mem_responder_byte_merge.sv
// dm_byte_merge
//   Combinational byte-lane merge: every lane whose enable bit is set takes
//   the new data, all other lanes keep the old word. Also used by the
//   store-side logic of the memory stage.
// Ports:
//   i_oldWord     current memory word
//   i_newData     lane-aligned store data
//   i_byteEnable  one bit per byte lane, bit i covers bits [8i+7:8i]
//   o_mergedWord  resulting word
module dm_byte_merge
  import data_mem_responder_pkg::*;
#(
  parameter int DWIDTH = DM_DEFAULT_DWIDTH
) (
  input  logic [DWIDTH-1:0]   i_oldWord,
  input  logic [DWIDTH-1:0]   i_newData,
  input  logic [DWIDTH/8-1:0] i_byteEnable,
  output logic [DWIDTH-1:0]   o_mergedWord
);

  localparam int LANES = dmLanes(DWIDTH);

  // Start from the old word and overwrite only the enabled lanes
  always_comb begin
    o_mergedWord = i_oldWord;
    for (int i = 0; i < LANES; i++) begin
      if (i_byteEnable[i]) begin
        o_mergedWord[8*i +: 8] = i_newData[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Word-addressed data-memory responder for the memory-stage load/store bus.
//   A request is accepted in IDLE when cyc && stb, spends LATENCY cycles in
//   WAIT (stall high), then the access is committed on the edge entering RESP,
//   where ack pulses for one cycle. Dropping cyc before RESP aborts the access.
// Optional build macro:
//   DM_ERR_EN  adds dm_o_err; out-of-range or we&&rd requests then pulse err
//              instead of ack and perform no access.
// Ports:
//   dm_clk, dm_rst            clock, asynchronous active-high reset
//   dm_i_cyc, dm_i_stb        bus cycle valid, request strobe
//   dm_i_we, dm_i_rd          write / read request
//   dm_i_byte_enable          write byte lanes
//   dm_i_load_addr            read word address
//   dm_i_store_addr           write word address
//   dm_i_data_store           lane-aligned write data
//   dm_o_read_data            read data, held until the next committed read
//   dm_o_ack                  one-cycle completion pulse
//   dm_o_err                  one-cycle error pulse (DM_ERR_EN only)
//   dm_o_stall                request cannot be accepted this cycle
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DWIDTH  = DM_DEFAULT_DWIDTH,
  parameter int AWIDTH  = 5,
  parameter int DEPTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic                dm_clk,
  input  logic                dm_rst,
  input  logic                dm_i_cyc,
  input  logic                dm_i_stb,
  input  logic                dm_i_we,
  input  logic                dm_i_rd,
  input  logic [DWIDTH/8-1:0] dm_i_byte_enable,
  input  logic [AWIDTH-1:0]   dm_i_load_addr,
  input  logic [AWIDTH-1:0]   dm_i_store_addr,
  input  logic [DWIDTH-1:0]   dm_i_data_store,
  output logic [DWIDTH-1:0]   dm_o_read_data,
  output logic                dm_o_ack,
`ifdef DM_ERR_EN
  output logic                dm_o_err,
`endif
  output logic                dm_o_stall
);

  localparam int LANES = dmLanes(DWIDTH);
  localparam int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AWIDTH:0]   DEPTH_LIM = (AWIDTH+1)'(DEPTH);
  localparam logic [DM_CNT_W-1:0] WAIT_INIT = DM_CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  dmState_t r_state;
  dmState_t w_nextState;
  logic [DM_CNT_W-1:0] r_waitCnt;
  logic [DM_CNT_W-1:0] w_nextWaitCnt;
  logic w_accept;
  logic w_commit;

  // Request captured at acceptance
  logic              r_we;
  logic              r_rd;
  logic [LANES-1:0]  r_be;
  logic [AWIDTH-1:0] r_loadAddr;
  logic [AWIDTH-1:0] r_storeAddr;
  logic [DWIDTH-1:0] r_storeData;

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [DWIDTH-1:0] r_readData;
  logic              r_respErr;

  // Effective request fields
  logic              w_we;
  logic              w_rd;
  logic [LANES-1:0]  w_be;
  logic [AWIDTH-1:0] w_loadAddr;
  logic [AWIDTH-1:0] w_storeAddr;
  logic [DWIDTH-1:0] w_storeData;
  logic              w_loadInRange;
  logic              w_storeInRange;
  logic [IDXW-1:0]   w_loadIdx;
  logic [IDXW-1:0]   w_storeIdx;
  logic [DWIDTH-1:0] w_memRead;
  logic [DWIDTH-1:0] w_mergedWord;
  logic              w_isErr;
  logic              w_doWrite;
  logic              w_doRead;

  // With LATENCY=0 the commit happens on the accept edge itself, before the
  // request registers are loaded, so in IDLE the live bus fields are used.
  assign w_we        = (r_state == DM_IDLE) ? dm_i_we          : r_we;
  assign w_rd        = (r_state == DM_IDLE) ? dm_i_rd          : r_rd;
  assign w_be        = (r_state == DM_IDLE) ? dm_i_byte_enable : r_be;
  assign w_loadAddr  = (r_state == DM_IDLE) ? dm_i_load_addr   : r_loadAddr;
  assign w_storeAddr = (r_state == DM_IDLE) ? dm_i_store_addr  : r_storeAddr;
  assign w_storeData = (r_state == DM_IDLE) ? dm_i_data_store  : r_storeData;

  assign w_loadInRange  = ({1'b0, w_loadAddr}  < DEPTH_LIM);
  assign w_storeInRange = ({1'b0, w_storeAddr} < DEPTH_LIM);
  assign w_loadIdx      = w_loadAddr[IDXW-1:0];
  assign w_storeIdx     = w_storeAddr[IDXW-1:0];
  assign w_memRead      = w_loadInRange ? r_mem[w_loadIdx] : '0;

`ifdef DM_ERR_EN
  assign w_isErr = (w_we && w_rd) || (w_we && !w_storeInRange) ||
                   (!w_we && w_rd && !w_loadInRange);
`else
  assign w_isErr = 1'b0;
`endif

  // we has priority over rd; out-of-range writes are silently dropped
  assign w_doWrite = w_commit && w_we && w_storeInRange && !w_isErr;
  assign w_doRead  = w_commit && w_rd && !w_we && !w_isErr;

  dm_byte_merge #(
    .DWIDTH(DWIDTH)
  ) u_byteMerge (
    .i_oldWord   (r_mem[w_storeIdx]),
    .i_newData   (w_storeData),
    .i_byteEnable(w_be),
    .o_mergedWord(w_mergedWord)
  );

  // Next-state logic; w_commit marks an edge that enters RESP with cyc held
  always_comb begin
    w_nextState   = r_state;
    w_nextWaitCnt = r_waitCnt;
    w_accept      = 1'b0;
    w_commit      = 1'b0;
    case (r_state)
      DM_IDLE: begin
        if (dm_i_cyc && dm_i_stb) begin
          w_accept = 1'b1;
          if (LATENCY == 0) begin
            w_nextState = DM_RESP;
            w_commit    = 1'b1;
          end else begin
            w_nextState   = DM_WAIT;
            w_nextWaitCnt = WAIT_INIT;
          end
        end
      end
      DM_WAIT: begin
        if (!dm_i_cyc) begin
          w_nextState = DM_IDLE;
        end else if (r_waitCnt == '0) begin
          w_nextState = DM_RESP;
          w_commit    = 1'b1;
        end else begin
          w_nextWaitCnt = r_waitCnt - 1'b1;
        end
      end
      DM_RESP: begin
        w_nextState = DM_IDLE;
      end
      default: begin
        w_nextState = DM_IDLE;
      end
    endcase
  end

  // State, wait counter and response kind
  always_ff @(posedge dm_clk or posedge dm_rst) begin
    if (dm_rst) begin
      r_state   <= DM_IDLE;
      r_waitCnt <= '0;
      r_respErr <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_nextWaitCnt;
      if (w_commit) begin
        r_respErr <= w_isErr;
      end
    end
  end

  // Capture the request at acceptance so the bus may move on during WAIT
  always_ff @(posedge dm_clk or posedge dm_rst) begin
    if (dm_rst) begin
      r_we        <= 1'b0;
      r_rd        <= 1'b0;
      r_be        <= '0;
      r_loadAddr  <= '0;
      r_storeAddr <= '0;
      r_storeData <= '0;
    end else if (w_accept) begin
      r_we        <= dm_i_we;
      r_rd        <= dm_i_rd;
      r_be        <= dm_i_byte_enable;
      r_loadAddr  <= dm_i_load_addr;
      r_storeAddr <= dm_i_store_addr;
      r_storeData <= dm_i_data_store;
    end
  end

  // Memory array and read-data register, both cleared by reset
  always_ff @(posedge dm_clk or posedge dm_rst) begin
    if (dm_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_readData <= '0;
    end else begin
      if (w_doWrite) begin
        r_mem[w_storeIdx] <= w_mergedWord;
      end
      if (w_doRead) begin
        r_readData <= w_memRead;
      end
    end
  end

  assign dm_o_read_data = r_readData;
  assign dm_o_stall     = (r_state != DM_IDLE);
  assign dm_o_ack       = (r_state == DM_RESP) && !r_respErr;
`ifdef DM_ERR_EN
  assign dm_o_err       = (r_state == DM_RESP) && r_respErr;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Three responders with different shapes share one bench:
//     0: LATENCY=1, DEPTH=16 (range checks)
//     1: LATENCY=3, DEPTH=32 (wait counter, aborts, async reset)
//     2: LATENCY=0, DEPTH=32 (back-to-back)
//   A vector table drives complete transactions; expected results are queued
//   at drive time and popped when the responder acks.
module tb_data_mem_responder;

  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc   [NDUT];
  logic        stb   [NDUT];
  logic        we    [NDUT];
  logic        rdReq [NDUT];
  logic [3:0]  be    [NDUT];
  logic [4:0]  laddr [NDUT];
  logic [4:0]  saddr [NDUT];
  logic [31:0] wdata [NDUT];
  logic [31:0] rdata [NDUT];
  logic        ack   [NDUT];
  logic        stall [NDUT];
  logic        err   [NDUT];

  typedef struct {
    int          d;
    logic        we;
    logic        rd;
    logic [3:0]  be;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] expData;
    logic [31:0] expDataErr;
    logic        errCase;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        isErr;
  } exp_t;

  exp_t        expQ [$];
  logic [31:0] lastRead [NDUT];
  vec_t        vecs [22];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DWIDTH(32), .AWIDTH(5), .DEPTH(16), .LATENCY(1)) u_dut0 (
    .dm_clk(clk), .dm_rst(rst), .dm_i_cyc(cyc[0]), .dm_i_stb(stb[0]),
    .dm_i_we(we[0]), .dm_i_rd(rdReq[0]), .dm_i_byte_enable(be[0]),
    .dm_i_load_addr(laddr[0]), .dm_i_store_addr(saddr[0]),
    .dm_i_data_store(wdata[0]), .dm_o_read_data(rdata[0]), .dm_o_ack(ack[0]),
`ifdef DM_ERR_EN
    .dm_o_err(err[0]),
`endif
    .dm_o_stall(stall[0]));

  data_mem_responder #(.DWIDTH(32), .AWIDTH(5), .DEPTH(32), .LATENCY(3)) u_dut1 (
    .dm_clk(clk), .dm_rst(rst), .dm_i_cyc(cyc[1]), .dm_i_stb(stb[1]),
    .dm_i_we(we[1]), .dm_i_rd(rdReq[1]), .dm_i_byte_enable(be[1]),
    .dm_i_load_addr(laddr[1]), .dm_i_store_addr(saddr[1]),
    .dm_i_data_store(wdata[1]), .dm_o_read_data(rdata[1]), .dm_o_ack(ack[1]),
`ifdef DM_ERR_EN
    .dm_o_err(err[1]),
`endif
    .dm_o_stall(stall[1]));

  data_mem_responder #(.DWIDTH(32), .AWIDTH(5), .DEPTH(32), .LATENCY(0)) u_dut2 (
    .dm_clk(clk), .dm_rst(rst), .dm_i_cyc(cyc[2]), .dm_i_stb(stb[2]),
    .dm_i_we(we[2]), .dm_i_rd(rdReq[2]), .dm_i_byte_enable(be[2]),
    .dm_i_load_addr(laddr[2]), .dm_i_store_addr(saddr[2]),
    .dm_i_data_store(wdata[2]), .dm_o_read_data(rdata[2]), .dm_o_ack(ack[2]),
`ifdef DM_ERR_EN
    .dm_o_err(err[2]),
`endif
    .dm_o_stall(stall[2]));

`ifndef DM_ERR_EN
  assign err[0] = 1'b0;
  assign err[1] = 1'b0;
  assign err[2] = 1'b0;
`endif

  function automatic int latOf(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 0);
  endfunction

  function automatic vec_t mkVec(input int d, input logic w, input logic r,
                                 input logic [3:0] b, input logic [4:0] a,
                                 input logic [31:0] dat, input logic [31:0] ex,
                                 input logic [31:0] exErr, input logic ec);
    vec_t v;
    v.d = d; v.we = w; v.rd = r; v.be = b; v.addr = a; v.data = dat;
    v.expData = ex; v.expDataErr = exErr; v.errCase = ec;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // One full transaction: accept, wait for the response, check it, then
  // drop cyc inside RESP (the access is already committed there).
  task automatic applyStimulus(input int d, input logic w, input logic r,
                               input logic [3:0] b, input logic [4:0] a,
                               input logic [31:0] dat, input logic [31:0] ex,
                               input logic [31:0] exErr, input logic ec,
                               input string tag);
    exp_t e;
    int   cycles;
    int   stallLow;
    logic expErr;
    logic [31:0] readExp;
    expErr  = 1'b0;
    readExp = ex;
`ifdef DM_ERR_EN
    expErr  = ec;
    readExp = exErr;
`endif
    @(negedge clk);
    checkOutput({tag, " idleStall"}, 32'(stall[d]), 32'd0);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; rdReq[d] = r; be[d] = b;
    laddr[d] = a; saddr[d] = a; wdata[d] = dat;
    e.isErr = expErr;
    e.data  = (r && !w) ? readExp : lastRead[d];
    expQ.push_back(e);
    @(negedge clk);
    // Scramble the bus so a responder that does not latch the request is caught
    stb[d] = 1'b0; we[d] = ~w; rdReq[d] = ~r; be[d] = ~b;
    laddr[d] = ~a; saddr[d] = ~a; wdata[d] = ~dat;
    cycles = 1; stallLow = 0;
    while (!(ack[d] || err[d]) && cycles < 40) begin
      if (!stall[d]) stallLow++;
      @(negedge clk);
      cycles++;
    end
    e = expQ.pop_front();
    if (cycles >= 40) begin
      checks++; errors++;
      $display("[TB] FAIL %s timeout: no response after %0d cycles, expected %0d", tag, cycles, latOf(d) + 1);
      cyc[d] = 1'b0; stb[d] = 1'b0;
      return;
    end
    checkOutput({tag, " latency"}, 32'(cycles), 32'(latOf(d) + 1));
    checkOutput({tag, " stallWait"}, 32'(stallLow), 32'd0);
    checkOutput({tag, " stallResp"}, 32'(stall[d]), 32'd1);
    checkOutput({tag, " ack"}, 32'(ack[d]), 32'(!e.isErr));
`ifdef DM_ERR_EN
    checkOutput({tag, " err"}, 32'(err[d]), 32'(e.isErr));
`endif
    checkOutput({tag, " readData"}, rdata[d], e.data);
    lastRead[d] = e.data;
    cyc[d] = 1'b0; we[d] = 1'b0; rdReq[d] = 1'b0;
    @(negedge clk);
    checkOutput({tag, " ackPulse"}, 32'(ack[d] | err[d]), 32'd0);
  endtask

  // Accept a write, then drop cyc after dropAfter cycles; nothing may respond
  task automatic abortTxn(input int d, input logic [4:0] a, input logic [31:0] dat,
                          input int dropAfter, input string tag);
    int hits;
    hits = 0;
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b1; rdReq[d] = 1'b0; be[d] = 4'hF;
    laddr[d] = a; saddr[d] = a; wdata[d] = dat;
    @(negedge clk);
    stb[d] = 1'b0;
    if (ack[d] || err[d]) hits++;
    for (int i = 1; i < dropAfter; i++) begin
      @(negedge clk);
      if (ack[d] || err[d]) hits++;
    end
    cyc[d] = 1'b0; we[d] = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ack[d] || err[d]) hits++;
    end
    checkOutput({tag, " noAck"}, 32'(hits), 32'd0);
    checkOutput({tag, " stallIdle"}, 32'(stall[d]), 32'd0);
    checkOutput({tag, " readHeld"}, rdata[d], lastRead[d]);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] ackBits;
    logic [3:0] stallBits;

    vecs[0]  = mkVec(0, 1, 0, 4'hF, 5'd3,  32'hDEADBEEF, 32'h0,        32'h0,        0);
    vecs[1]  = mkVec(0, 0, 1, 4'hF, 5'd3,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 0);
    vecs[2]  = mkVec(0, 1, 0, 4'hF, 5'd5,  32'h11223344, 32'h0,        32'h0,        0);
    vecs[3]  = mkVec(0, 1, 0, 4'h5, 5'd5,  32'hAABBCCDD, 32'h0,        32'h0,        0);
    vecs[4]  = mkVec(0, 0, 1, 4'hF, 5'd5,  32'h0,        32'h11BB33DD, 32'h11BB33DD, 0);
    vecs[5]  = mkVec(0, 1, 0, 4'h0, 5'd5,  32'hFFFFFFFF, 32'h0,        32'h0,        0);
    vecs[6]  = mkVec(0, 0, 1, 4'hF, 5'd5,  32'h0,        32'h11BB33DD, 32'h11BB33DD, 0);
    vecs[7]  = mkVec(0, 1, 0, 4'hF, 5'd20, 32'h12345678, 32'h0,        32'h0,        1);
    vecs[8]  = mkVec(0, 0, 1, 4'hF, 5'd20, 32'h0,        32'h0,        32'h11BB33DD, 1);
    vecs[9]  = mkVec(0, 1, 0, 4'hF, 5'd15, 32'h0F0F0F0F, 32'h0,        32'h0,        0);
    vecs[10] = mkVec(0, 0, 1, 4'hF, 5'd15, 32'h0,        32'h0F0F0F0F, 32'h0F0F0F0F, 0);
    vecs[11] = mkVec(0, 1, 0, 4'hF, 5'd16, 32'h00000001, 32'h0,        32'h0,        1);
    vecs[12] = mkVec(0, 0, 1, 4'hF, 5'd16, 32'h0,        32'h0,        32'h0F0F0F0F, 1);
    vecs[13] = mkVec(0, 0, 1, 4'hF, 5'd0,  32'h0,        32'h0,        32'h0,        0);
    vecs[14] = mkVec(0, 1, 1, 4'hF, 5'd3,  32'h01020304, 32'h0,        32'h0,        1);
    vecs[15] = mkVec(0, 0, 1, 4'hF, 5'd3,  32'h0,        32'h01020304, 32'hDEADBEEF, 0);
    vecs[16] = mkVec(0, 0, 0, 4'hF, 5'd3,  32'h0,        32'h0,        32'h0,        0);
    vecs[17] = mkVec(1, 1, 0, 4'hF, 5'd7,  32'h13579BDF, 32'h0,        32'h0,        0);
    vecs[18] = mkVec(1, 0, 1, 4'hF, 5'd7,  32'h0,        32'h13579BDF, 32'h13579BDF, 0);
    vecs[19] = mkVec(2, 0, 1, 4'hF, 5'd1,  32'h0,        32'h0,        32'h0,        0);
    vecs[20] = mkVec(2, 1, 0, 4'hF, 5'd1,  32'h5A5A5A5A, 32'h0,        32'h0,        0);
    vecs[21] = mkVec(2, 0, 1, 4'hF, 5'd1,  32'h0,        32'h5A5A5A5A, 32'h5A5A5A5A, 0);

    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; rdReq[d] = 1'b0; be[d] = 4'h0;
      laddr[d] = 5'd0; saddr[d] = 5'd0; wdata[d] = 32'h0; lastRead[d] = 32'h0;
    end

    repeat (2) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      checkOutput($sformatf("reset%0d readData", d), rdata[d], 32'h0);
      checkOutput($sformatf("reset%0d ack", d), 32'(ack[d]), 32'd0);
      checkOutput($sformatf("reset%0d stall", d), 32'(stall[d]), 32'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].d, vecs[i].we, vecs[i].rd, vecs[i].be, vecs[i].addr,
                    vecs[i].data, vecs[i].expData, vecs[i].expDataErr,
                    vecs[i].errCase, $sformatf("vec%0d", i));
    end

    // Aborts: during WAIT, and on the edge that would enter RESP
    abortTxn(1, 5'd9, 32'hCAFEF00D, 1, "abortWait");
    applyStimulus(1, 0, 1, 4'hF, 5'd9, 32'h0, 32'h0, 32'h0, 0, "abortWaitRead");
    abortTxn(1, 5'd10, 32'h55555555, 3, "abortLastWait");
    applyStimulus(1, 0, 1, 4'hF, 5'd10, 32'h0, 32'h0, 32'h0, 0, "abortLastRead");
    abortTxn(0, 5'd4, 32'h99999999, 1, "abortEnterResp");
    applyStimulus(0, 0, 1, 4'hF, 5'd4, 32'h0, 32'h0, 32'h0, 0, "abortEnterRead");

    // LATENCY=0 with stb held high: requests during RESP are ignored
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; rdReq[2] = 1'b1; laddr[2] = 5'd1;
    ackBits = 4'h0; stallBits = 4'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ackBits   = {ackBits[2:0], ack[2]};
      stallBits = {stallBits[2:0], stall[2]};
    end
    cyc[2] = 1'b0; stb[2] = 1'b0; rdReq[2] = 1'b0;
    checkOutput("b2b ackPattern", 32'(ackBits), 32'h0000000A);
    checkOutput("b2b stallPattern", 32'(stallBits), 32'h0000000A);
    checkOutput("b2b readData", rdata[2], 32'h5A5A5A5A);
    @(negedge clk);

    // Async reset in the middle of WAIT
    applyStimulus(1, 0, 1, 4'hF, 5'd7, 32'h0, 32'h13579BDF, 32'h13579BDF, 0, "preReset");
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF;
    saddr[1] = 5'd2; laddr[1] = 5'd2; wdata[1] = 32'hABCD1234;
    @(negedge clk);
    stb[1] = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("midReset ack", 32'(ack[1]), 32'd0);
    checkOutput("midReset stall", 32'(stall[1]), 32'd0);
    checkOutput("midReset readData", rdata[1], 32'h0);
    checkOutput("midReset readData0", rdata[0], 32'h0);
    @(negedge clk);
    rst = 1'b0; cyc[1] = 1'b0; we[1] = 1'b0;
    for (int d = 0; d < NDUT; d++) lastRead[d] = 32'h0;
    applyStimulus(1, 0, 1, 4'hF, 5'd7, 32'h0, 32'h0, 32'h0, 0, "postResetA7");
    applyStimulus(1, 0, 1, 4'hF, 5'd2, 32'h0, 32'h0, 32'h0, 0, "postResetA2");
    applyStimulus(0, 0, 1, 4'hF, 5'd3, 32'h0, 32'h0, 32'h0, 0, "postResetD0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
